instr_mem_prog: RTL and testbench

Parametrised, runtime-programmable instruction memory for the MIPS pipeline IF stage.
- A byte-stream loader port, driven by the debug/UART unit, fills memory with whole words before execution.
- The fetch port gives synchronous, byte-addressed reads with stall and flush support.
- HALT detection during load, plus a loaded-word count, lets the debug unit know the program size.

---
 rtl/instr_mem_pkg.sv | 15 +
 rtl/instr_mem_prog_word_assembler.sv | 52 +++++
 rtl/instr_mem_prog.sv | 133 +++++++++++++
 tb/tb_instr_mem_prog.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared constants and FSM state type for the programmable instruction memory.
package instr_mem_pkg;

   localparam int BYTE_W = 8;

   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

endpackage

// File: rtl/instr_mem_prog_word_assembler.sv
// Packs an MSB-first byte stream into NBITS-wide words; word_valid marks the
// cycle in which the last byte of a word arrives, so the word can be written then.
module word_assembler
   import instr_mem_pkg::*;
#(
   parameter int NBITS = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic [NBITS-1:0]  word,
   output logic              word_valid
);

   localparam int BPW   = NBITS / BYTE_W;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CNT_W-1:0] count_q;

   assign word_valid = byte_valid && !clear && (count_q == CNT_W'(BPW - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (byte_valid) begin
         count_q <= word_valid ? '0 : count_q + 1'b1;
      end
   end

   if (BPW > 1) begin : g_multi
      logic [NBITS-BYTE_W-1:0] shift_q;

      assign word = {shift_q, byte_in};

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shift_q <= '0;
         end else if (clear) begin
            shift_q <= '0;
         end else if (byte_valid) begin
            shift_q <= word[NBITS-BYTE_W-1:0];
         end
      end
   end else begin : g_single
      assign word = byte_in;
   end

endmodule

// File: rtl/instr_mem_prog.sv
// Runtime-programmable instruction memory: byte-stream loader plus IF-stage fetch port.
// Optional debug readback port enabled by defining INSTR_MEM_READBACK_EN.
module instr_mem_prog
   import instr_mem_pkg::*;
#(
   parameter int NBITS          = 32,
   parameter int DEPTH          = 256,
   parameter int ADDR_W         = $clog2(DEPTH),
   parameter int BYTES_PER_WORD = NBITS / 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [NBITS-1:0]  i_PC,
   input  logic              i_stall,
   input  logic              i_flush,
   output logic [NBITS-1:0]  o_Instruction,
   output logic              o_valid,
   output logic              o_misaligned,
   input  logic              i_prog_start,
   input  logic [7:0]        i_load_byte,
   input  logic              i_load_valid,
   output logic              o_load_ready,
   output logic              o_prog_done,
   output logic [ADDR_W:0]   o_words_loaded
`ifdef INSTR_MEM_READBACK_EN
   ,
   input  logic [ADDR_W-1:0] i_dbg_addr,
   output logic [NBITS-1:0]  o_dbg_data
`endif
);

   localparam logic [NBITS-1:0] NOP_WORD  = {BYTES_PER_WORD{NOP_INSTR[BYTE_W-1:0]}};
   localparam logic [NBITS-1:0] HALT_WORD = {BYTES_PER_WORD{HALT_INSTR[BYTE_W-1:0]}};

   state_t             state;
   logic [ADDR_W:0]    words_q;
   logic               accept;
   logic [NBITS-1:0]   asm_word;
   logic               asm_valid;
   logic [NBITS-1:0]   mem [DEPTH];
   logic [NBITS-1:0]   rd_data;
   logic [ADDR_W-1:0]  fetch_idx;
   logic               in_range;
   logic               fetch_en;
   logic               unused_pc;

   assign o_words_loaded = words_q;

   // A simultaneous i_prog_start always wins over the incoming byte.
   assign accept = (state == LOAD) && i_load_valid && !i_prog_start;

   word_assembler #(
      .NBITS(NBITS)
   ) u_assembler (
      .clk       (i_clk),
      .rst_n     (i_rst_n),
      .clear     (i_prog_start),
      .byte_in   (i_load_byte),
      .byte_valid(accept),
      .word      (asm_word),
      .word_valid(asm_valid)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         words_q      <= '0;
         o_load_ready <= 1'b0;
         o_prog_done  <= 1'b0;
      end else if (i_prog_start) begin
         state        <= LOAD;
         words_q      <= '0;
         o_load_ready <= 1'b1;
         o_prog_done  <= 1'b0;
      end else if (state == LOAD && asm_valid) begin
         words_q <= words_q + 1'b1;
         if (asm_word == HALT_WORD || (words_q + 1'b1) == (ADDR_W + 1)'(DEPTH)) begin
            state        <= RUN;
            o_load_ready <= 1'b0;
            o_prog_done  <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (asm_valid) begin
         mem[words_q[ADDR_W-1:0]] <= asm_word;
      end
   end

   assign fetch_idx = i_PC[ADDR_W+1:2];
   assign in_range  = {1'b0, fetch_idx} < words_q;
   assign fetch_en  = (state == RUN) && !i_stall;
   assign unused_pc = ^{i_PC[NBITS-1:ADDR_W+2]};

   // The read register has no reset so it maps onto block RAM; o_valid masks it to NOP.
   always_ff @(posedge i_clk) begin
      if (fetch_en) begin
         rd_data <= mem[fetch_idx];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid      <= 1'b0;
         o_misaligned <= 1'b0;
      end else if (state != RUN) begin
         o_valid      <= 1'b0;
         o_misaligned <= 1'b0;
      end else if (!i_stall) begin
         if (i_flush) begin
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
         end else begin
            o_valid      <= in_range;
            o_misaligned <= |i_PC[1:0];
         end
      end
   end

   assign o_Instruction = o_valid ? rd_data : NOP_WORD;

`ifdef INSTR_MEM_READBACK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dbg_data <= '0;
      end else begin
         o_dbg_data <= mem[i_dbg_addr];
      end
   end
`endif

endmodule

// File: tb/tb_instr_mem_prog.sv
// Self-checking bench for instr_mem_prog: behavioural model, fetch vector table, random phases.
module tb_instr_mem_prog;
   import instr_mem_pkg::*;

   localparam int NBITS  = 32;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic [NBITS-1:0]  i_PC;
   logic              i_stall;
   logic              i_flush;
   logic [NBITS-1:0]  o_Instruction;
   logic              o_valid;
   logic              o_misaligned;
   logic              i_prog_start;
   logic [7:0]        i_load_byte;
   logic              i_load_valid;
   logic              o_load_ready;
   logic              o_prog_done;
   logic [ADDR_W:0]   o_words_loaded;
`ifdef INSTR_MEM_READBACK_EN
   logic [ADDR_W-1:0] i_dbg_addr;
   logic [NBITS-1:0]  o_dbg_data;
`endif

   always #5 i_clk = ~i_clk;

   instr_mem_prog #(
      .NBITS(NBITS),
      .DEPTH(DEPTH)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_PC          (i_PC),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_Instruction (o_Instruction),
      .o_valid       (o_valid),
      .o_misaligned  (o_misaligned),
      .i_prog_start  (i_prog_start),
      .i_load_byte   (i_load_byte),
      .i_load_valid  (i_load_valid),
      .o_load_ready  (o_load_ready),
      .o_prog_done   (o_prog_done),
      .o_words_loaded(o_words_loaded)
`ifdef INSTR_MEM_READBACK_EN
      ,
      .i_dbg_addr    (i_dbg_addr),
      .o_dbg_data    (o_dbg_data)
`endif
   );

   // Reference model: program held as a word array, pending bytes as a queue.
   logic [NBITS-1:0] m_mem [DEPTH];
   logic [7:0]       m_bytes [$];
   int               m_words;
   bit               m_loading;
   bit               m_running;
   logic [NBITS-1:0] m_instr;
   bit               m_valid;
   bit               m_mis;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [NBITS-1:0] pc;
      logic             stall;
      logic             flush;
      logic [NBITS-1:0] instr;
      logic             valid;
      logic             mis;
   } vec_t;

   vec_t vecs [$];

   task automatic modelReset();
      m_bytes.delete();
      m_words   = 0;
      m_loading = 0;
      m_running = 0;
      m_instr   = '0;
      m_valid   = 0;
      m_mis     = 0;
   endtask

   task automatic modelStep(input logic ps, input logic lv, input logic [7:0] lb,
                            input logic [NBITS-1:0] pc, input logic st, input logic fl);
      logic [NBITS-1:0] w;
      int idx;
      if (!m_running) begin
         m_instr = '0;
         m_valid = 0;
         m_mis   = 0;
      end else if (!st) begin
         if (fl) begin
            m_instr = '0;
            m_valid = 0;
            m_mis   = 0;
         end else begin
            idx   = int'(pc / 4) % DEPTH;
            m_mis = (pc % 4) != 0;
            if (idx < m_words) begin
               m_instr = m_mem[idx];
               m_valid = 1;
            end else begin
               m_instr = '0;
               m_valid = 0;
            end
         end
      end
      if (ps) begin
         m_bytes.delete();
         m_words   = 0;
         m_loading = 1;
         m_running = 0;
      end else if (m_loading && lv) begin
         m_bytes.push_back(lb);
         if (m_bytes.size() == NBITS / 8) begin
            w = '0;
            foreach (m_bytes[i]) w = (w << 8) | NBITS'(m_bytes[i]);
            m_bytes.delete();
            m_mem[m_words] = w;
            m_words++;
            if (w == HALT_INSTR || m_words == DEPTH) begin
               m_loading = 0;
               m_running = 1;
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
   endtask

   task automatic checkOutput();
      check("instruction", 64'(o_Instruction), 64'(m_instr));
      check("valid", 64'(o_valid), 64'(m_valid));
      check("misaligned", 64'(o_misaligned), 64'(m_mis));
      check("load_ready", 64'(o_load_ready), 64'(m_loading));
      check("prog_done", 64'(o_prog_done), 64'(m_running));
      check("words_loaded", 64'(o_words_loaded), 64'(m_words));
   endtask

   task automatic applyStimulus(input logic ps, input logic lv, input logic [7:0] lb,
                                input logic [NBITS-1:0] pc, input logic st, input logic fl);
      i_prog_start = ps;
      i_load_valid = lv;
      i_load_byte  = lb;
      i_PC         = pc;
      i_stall      = st;
      i_flush      = fl;
      modelStep(ps, lv, lb, pc, st, fl);
      @(posedge i_clk);
      #1;
      checkOutput();
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 1'b1, b, '0, 1'b0, 1'b0);
   endtask

   task automatic startProg();
      applyStimulus(1'b1, 1'b0, 8'h00, '0, 1'b0, 1'b0);
   endtask

   task automatic addVec(input logic [NBITS-1:0] pc, input logic st, input logic fl,
                         input logic [NBITS-1:0] instr, input logic valid, input logic mis);
      vec_t v;
      v.pc = pc; v.stall = st; v.flush = fl; v.instr = instr; v.valid = valid; v.mis = mis;
      vecs.push_back(v);
   endtask

   initial begin
      logic [NBITS-1:0] w;
      logic [7:0] prog1 [12];

      prog1 = '{8'h00, 8'h22, 8'h08, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hFF, 8'hFF, 8'hFF, 8'hFF};

      // Fetch vectors against the 3-word program 00220820, 01020304, FFFFFFFF.
      addVec(32'd0,  0, 0, 32'h0022_0820, 1, 0);
      addVec(32'd4,  0, 0, 32'h0102_0304, 1, 0);
      addVec(32'd8,  0, 0, 32'hFFFF_FFFF, 1, 0);
      addVec(32'd12, 0, 0, 32'h0000_0000, 0, 0);
      addVec(32'd0,  0, 0, 32'h0022_0820, 1, 0);
      addVec(32'd4,  1, 0, 32'h0022_0820, 1, 0);
      addVec(32'd8,  1, 0, 32'h0022_0820, 1, 0);
      addVec(32'd12, 1, 0, 32'h0022_0820, 1, 0);
      addVec(32'd4,  0, 1, 32'h0000_0000, 0, 0);
      addVec(32'd8,  0, 0, 32'hFFFF_FFFF, 1, 0);
      addVec(32'd4,  1, 1, 32'hFFFF_FFFF, 1, 0);
      addVec(32'd6,  0, 0, 32'h0102_0304, 1, 1);
      addVec(32'd0,  0, 0, 32'h0022_0820, 1, 0);

      i_rst_n = 1'b0;
      i_prog_start = 0; i_load_valid = 0; i_load_byte = '0;
      i_PC = '0; i_stall = 0; i_flush = 0;
`ifdef INSTR_MEM_READBACK_EN
      i_dbg_addr = '0;
`endif
      modelReset();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      checkOutput();

      // Reset in the middle of a word load.
      startProg();
      sendByte(8'h12);
      sendByte(8'h34);
      i_rst_n = 1'b0;
      #2;
      modelReset();
      checkOutput();
      #2;
      i_rst_n = 1'b1;

      startProg();
      for (int i = 0; i < 8; i++) sendByte(prog1[i]);
      check("t1_words", 64'(o_words_loaded), 64'd2);
      check("t1_ready", 64'(o_load_ready), 64'd1);
      for (int i = 8; i < 12; i++) sendByte(prog1[i]);
      check("t2_done", 64'(o_prog_done), 64'd1);
      check("t2_words", 64'(o_words_loaded), 64'd3);
      sendByte(8'h55);
      sendByte(8'h66);
      check("t2_not_ready", 64'(o_load_ready), 64'd0);

      foreach (vecs[i]) begin
         applyStimulus(1'b0, 1'b0, 8'h00, vecs[i].pc, vecs[i].stall, vecs[i].flush);
         check($sformatf("vec%0d_instr", i), 64'(o_Instruction), 64'(vecs[i].instr));
         check($sformatf("vec%0d_valid", i), 64'(o_valid), 64'(vecs[i].valid));
         check($sformatf("vec%0d_mis", i), 64'(o_misaligned), 64'(vecs[i].mis));
      end

      for (int i = 0; i < 150; i++)
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), NBITS'($urandom_range(0, 31)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));

      // Fill all DEPTH words with no HALT, with gaps in the byte stream.
      startProg();
      for (int k = 0; k < DEPTH; k++) begin
         w = $urandom;
         if (w == HALT_INSTR) w = '0;
         for (int b = NBITS / 8 - 1; b >= 0; b--) begin
            while ($urandom_range(0, 2) == 0)
               applyStimulus(1'b0, 1'b0, 8'($urandom), NBITS'($urandom), 1'b0, 1'b0);
            sendByte(w[b*8 +: 8]);
         end
      end
      check("t6_done", 64'(o_prog_done), 64'd1);
      check("t6_words", 64'(o_words_loaded), 64'(DEPTH));

      for (int i = 0; i < 120; i++)
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), NBITS'($urandom_range(0, 31)),
                       1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) == 0));

      // Start with a simultaneous byte: the byte must be dropped.
      applyStimulus(1'b1, 1'b1, 8'hAA, '0, 1'b0, 1'b0);
      check("t6_restart_words", 64'(o_words_loaded), 64'd0);
      sendByte(8'h01);
      sendByte(8'h02);
      sendByte(8'h03);
      check("t6_drop_words", 64'(o_words_loaded), 64'd0);
      sendByte(8'h04);
      check("t6_one_word", 64'(o_words_loaded), 64'd1);
      sendByte(8'h09);
      startProg();
      for (int i = 0; i < 4; i++) sendByte(8'hFF);
      check("t6_halt_done", 64'(o_prog_done), 64'd1);
      applyStimulus(1'b0, 1'b0, 8'h00, 32'd0, 1'b0, 1'b0);
      check("t6_halt_fetch", 64'(o_Instruction), 64'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 8'h00, 32'd4, 1'b0, 1'b0);
      check("t6_outside", 64'(o_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
